// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: FSM state encoding and port addresses.
// Every 3-bit code is a real state, so the binary encoding has no spare codes.
package router_pkg;

   typedef logic [2:0] state_t;

   localparam state_t DECODE_ADDRESS     = 3'd0;
   localparam state_t LOAD_FIRST_DATA    = 3'd1;
   localparam state_t LOAD_DATA          = 3'd2;
   localparam state_t LOAD_PARITY        = 3'd3;
   localparam state_t CHECK_PARITY_ERROR = 3'd4;
   localparam state_t FIFO_FULL_STATE    = 3'd5;
   localparam state_t LOAD_AFTER_FULL    = 3'd6;
   localparam state_t WAIT_TILL_EMPTY    = 3'd7;

   // Destination addresses carried in the low two bits of the header byte.
   // The fourth code, 3, is invalid and is never routed.
   localparam logic [1:0] ADDR0 = 2'd0;
   localparam logic [1:0] ADDR1 = 2'd1;
   localparam logic [1:0] ADDR2 = 2'd2;

endpackage

// File: rtl/router_fsm.sv
// Control FSM of the 1x3 packet router: address decode, drain wait, header/payload/parity
// sequencing and FIFO-full back-pressure, with Moore one-hot strobes for the datapath.
module router_fsm
   import router_pkg::*;
(
   input  logic       clock,
   input  logic       resetn,
   input  logic       pkt_valid,
   input  logic [1:0] data_in,
   input  logic       parity_done,
   input  logic       low_pkt_valid,
   input  logic       fifo_full,
   input  logic       fifo_empty_0,
   input  logic       fifo_empty_1,
   input  logic       fifo_empty_2,
   input  logic       soft_reset_0,
   input  logic       soft_reset_1,
   input  logic       soft_reset_2,
   output logic       detect_add,
   output logic       lfd_state,
   output logic       ld_state,
   output logic       laf_state,
   output logic       full_state,
   output logic       write_enb_reg,
   output logic       rst_int_reg,
   output logic       busy
);

   state_t     state;
   state_t     state_next;
   logic [1:0] addr_q;
   logic       empty_in;
   logic       empty_addr;
   logic       soft_hit;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= DECODE_ADDRESS;
      end else begin
         state <= state_next;
      end
   end

   // The address is captured every cycle while decoding, so it already holds
   // the header's address on the edge that leaves DECODE_ADDRESS.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         addr_q <= ADDR0;
      end else if (state == DECODE_ADDRESS) begin
         addr_q <= data_in;
      end
   end

   always_comb begin
      empty_in = 1'b0;
      case (data_in)
         ADDR0:   empty_in = fifo_empty_0;
         ADDR1:   empty_in = fifo_empty_1;
         ADDR2:   empty_in = fifo_empty_2;
         default: empty_in = 1'b0;
      endcase
   end

   always_comb begin
      empty_addr = 1'b0;
      soft_hit   = 1'b0;
      case (addr_q)
         ADDR0: begin
            empty_addr = fifo_empty_0;
            soft_hit   = soft_reset_0;
         end
         ADDR1: begin
            empty_addr = fifo_empty_1;
            soft_hit   = soft_reset_1;
         end
         ADDR2: begin
            empty_addr = fifo_empty_2;
            soft_hit   = soft_reset_2;
         end
         default: begin
            empty_addr = 1'b0;
            soft_hit   = 1'b0;
         end
      endcase
   end

   always_comb begin
      state_next = DECODE_ADDRESS;
      case (state)
         DECODE_ADDRESS: begin
            if (pkt_valid && (data_in != 2'd3)) begin
               state_next = empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end else begin
               state_next = DECODE_ADDRESS;
            end
         end
         WAIT_TILL_EMPTY:    state_next = empty_addr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
         LOAD_FIRST_DATA:    state_next = LOAD_DATA;
         LOAD_DATA: begin
            if (fifo_full) begin
               state_next = FIFO_FULL_STATE;
            end else if (!pkt_valid) begin
               state_next = LOAD_PARITY;
            end else begin
               state_next = LOAD_DATA;
            end
         end
         FIFO_FULL_STATE:    state_next = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
         LOAD_AFTER_FULL: begin
            if (parity_done) begin
               state_next = DECODE_ADDRESS;
            end else if (low_pkt_valid) begin
               state_next = LOAD_PARITY;
            end else begin
               state_next = LOAD_DATA;
            end
         end
         LOAD_PARITY:        state_next = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR: state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
         default:            state_next = DECODE_ADDRESS;
      endcase
      // A read timeout on the selected port abandons the packet.
      if (soft_hit && (state != DECODE_ADDRESS)) begin
         state_next = DECODE_ADDRESS;
      end
   end

   assign detect_add    = (state == DECODE_ADDRESS);
   assign lfd_state     = (state == LOAD_FIRST_DATA);
   assign ld_state      = (state == LOAD_DATA);
   assign laf_state     = (state == LOAD_AFTER_FULL);
   assign full_state    = (state == FIFO_FULL_STATE);
   assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                          (state == LOAD_AFTER_FULL);
   assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
   assign busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: directed steps queue the expected strobe vector,
// and a negedge monitor pops and compares it against the DUT outputs.
module tb_router_fsm;

   logic       clock = 1'b0;
   logic       resetn;
   logic       pkt_valid;
   logic [1:0] data_in;
   logic       parity_done;
   logic       low_pkt_valid;
   logic       fifo_full;
   logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
   logic       soft_reset_0, soft_reset_1, soft_reset_2;
   logic       detect_add, lfd_state, ld_state, laf_state, full_state;
   logic       write_enb_reg, rst_int_reg, busy;

   // Expected vector order: {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
   localparam logic [7:0] E_DA  = 8'b1000_0000;
   localparam logic [7:0] E_LFD = 8'b0100_0001;
   localparam logic [7:0] E_LD  = 8'b0010_0100;
   localparam logic [7:0] E_LP  = 8'b0000_0101;
   localparam logic [7:0] E_CPE = 8'b0000_0011;
   localparam logic [7:0] E_FFS = 8'b0000_1001;
   localparam logic [7:0] E_LAF = 8'b0001_0101;
   localparam logic [7:0] E_WTE = 8'b0000_0001;

   typedef struct {
      string      name;
      logic [7:0] value;
   } expect_t;

   expect_t exp_q[$];
   int      checks   = 0;
   int      failures = 0;

   router_fsm dut (
      .clock         (clock),
      .resetn        (resetn),
      .pkt_valid     (pkt_valid),
      .data_in       (data_in),
      .parity_done   (parity_done),
      .low_pkt_valid (low_pkt_valid),
      .fifo_full     (fifo_full),
      .fifo_empty_0  (fifo_empty_0),
      .fifo_empty_1  (fifo_empty_1),
      .fifo_empty_2  (fifo_empty_2),
      .soft_reset_0  (soft_reset_0),
      .soft_reset_1  (soft_reset_1),
      .soft_reset_2  (soft_reset_2),
      .detect_add    (detect_add),
      .lfd_state     (lfd_state),
      .ld_state      (ld_state),
      .laf_state     (laf_state),
      .full_state    (full_state),
      .write_enb_reg (write_enb_reg),
      .rst_int_reg   (rst_int_reg),
      .busy          (busy)
   );

   always #5 clock = ~clock;

   // Monitor: every falling edge, compare the oldest pending expectation.
   initial begin
      expect_t e;
      logic [7:0] actual;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            actual = {detect_add, lfd_state, ld_state, laf_state, full_state,
                      write_enb_reg, rst_int_reg, busy};
            checks++;
            if (actual !== e.value) begin
               failures++;
               $display("[TB] FAIL %s: got %b, expected %b", e.name, actual, e.value);
            end
         end
      end
   end

   // Drive one cycle of inputs just after a falling edge and queue the
   // outputs expected after the following rising edge.
   task automatic applyStimulus(input string name, input logic pv, input logic [1:0] din,
                                input logic [2:0] empty, input logic full, input logic pd,
                                input logic lpv, input logic [2:0] sr, input logic [7:0] exp);
      expect_t e;
      @(negedge clock);
      #1;
      pkt_valid     = pv;
      data_in       = din;
      {fifo_empty_2, fifo_empty_1, fifo_empty_0} = empty;
      fifo_full     = full;
      parity_done   = pd;
      low_pkt_valid = lpv;
      {soft_reset_2, soft_reset_1, soft_reset_0} = sr;
      e.name  = name;
      e.value = exp;
      exp_q.push_back(e);
   endtask

   // Hold inputs through one rising edge, then pulse resetn between edges so
   // only an asynchronous reset can be visible at the next falling edge.
   task automatic checkOutput(input string name, input logic [7:0] exp);
      expect_t e;
      @(negedge clock);
      #1;
      e.name  = name;
      e.value = exp;
      exp_q.push_back(e);
      @(posedge clock);
      #1 resetn = 1'b0;
      #2 resetn = 1'b1;
   endtask

   initial begin
      resetn = 1'b0;
      pkt_valid = 1'b0; data_in = 2'd0; parity_done = 1'b0; low_pkt_valid = 1'b0;
      fifo_full = 1'b0; fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
      soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;

      applyStimulus("reset_c1", 0, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_DA);
      applyStimulus("reset_c2", 0, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_DA);
      resetn = 1'b1;

      // Normal packet to port 0
      applyStimulus("p0_lfd",  1, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LFD);
      applyStimulus("p0_ld",   1, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LD);
      applyStimulus("p0_ld2",  1, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LD);
      applyStimulus("p0_lp",   0, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LP);
      applyStimulus("p0_cpe",  0, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_CPE);
      applyStimulus("p0_da",   0, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_DA);

      // Port 1, FIFO fills during payload, pending parity after release
      applyStimulus("p1_lfd",  1, 2'd1, 3'b111, 0, 0, 0, 3'b000, E_LFD);
      applyStimulus("p1_ld",   1, 2'd1, 3'b111, 0, 0, 0, 3'b000, E_LD);
      applyStimulus("p1_ffs",  1, 2'd1, 3'b111, 1, 0, 0, 3'b000, E_FFS);
      applyStimulus("p1_ffs2", 0, 2'd1, 3'b111, 1, 0, 0, 3'b000, E_FFS);
      applyStimulus("p1_laf",  0, 2'd1, 3'b111, 0, 0, 0, 3'b000, E_LAF);
      applyStimulus("p1_lp",   0, 2'd1, 3'b111, 0, 0, 1, 3'b000, E_LP);
      applyStimulus("p1_cpe",  0, 2'd1, 3'b111, 0, 0, 0, 3'b000, E_CPE);
      applyStimulus("p1_da",   0, 2'd1, 3'b111, 0, 0, 0, 3'b000, E_DA);

      // Port 2, FIFO full in parity check, parity already done after release
      applyStimulus("p2_lfd",  1, 2'd2, 3'b111, 0, 0, 0, 3'b000, E_LFD);
      applyStimulus("p2_ld",   1, 2'd2, 3'b111, 0, 0, 0, 3'b000, E_LD);
      applyStimulus("p2_lp",   0, 2'd2, 3'b111, 0, 0, 0, 3'b000, E_LP);
      applyStimulus("p2_cpe",  0, 2'd2, 3'b111, 0, 0, 0, 3'b000, E_CPE);
      applyStimulus("p2_ffs",  0, 2'd2, 3'b111, 1, 0, 0, 3'b000, E_FFS);
      applyStimulus("p2_laf",  0, 2'd2, 3'b111, 0, 0, 0, 3'b000, E_LAF);
      applyStimulus("p2_da",   0, 2'd2, 3'b111, 0, 1, 0, 3'b000, E_DA);

      // Port 1 busy: wait for drain; in WTE the latched address must be used
      applyStimulus("wte",     1, 2'd1, 3'b101, 0, 0, 0, 3'b000, E_WTE);
      applyStimulus("wte_hold",1, 2'd0, 3'b101, 0, 0, 0, 3'b000, E_WTE);
      applyStimulus("wte_lfd", 1, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LFD);
      applyStimulus("wte_ld",  1, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LD);
      applyStimulus("wte_lp",  0, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LP);
      applyStimulus("wte_cpe", 0, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_CPE);
      applyStimulus("wte_da",  0, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_DA);

      // Invalid address 3 keeps the FSM decoding
      applyStimulus("addr3_a", 1, 2'd3, 3'b111, 0, 0, 0, 3'b000, E_DA);
      applyStimulus("addr3_b", 1, 2'd3, 3'b111, 0, 0, 0, 3'b000, E_DA);

      // Soft reset: only the selected port's timeout aborts
      applyStimulus("sr_lfd",  1, 2'd2, 3'b111, 0, 0, 0, 3'b000, E_LFD);
      applyStimulus("sr_ld",   1, 2'd2, 3'b111, 0, 0, 0, 3'b000, E_LD);
      applyStimulus("sr0_noop",1, 2'd2, 3'b111, 0, 0, 0, 3'b001, E_LD);
      applyStimulus("sr2_da",  1, 2'd2, 3'b111, 0, 0, 0, 3'b100, E_DA);

      // Asynchronous reset while stuck in FIFO_FULL_STATE
      applyStimulus("ar_lfd",  1, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LFD);
      applyStimulus("ar_ld",   1, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LD);
      applyStimulus("ar_ffs",  1, 2'd0, 3'b111, 1, 0, 0, 3'b000, E_FFS);
      checkOutput("async_rst", E_DA);
      applyStimulus("ar_idle", 0, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_DA);

      @(negedge clock);
      @(negedge clock);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
